// File: rtl/jtframe_msg_writer.sv
// Write-side companion of the message character RAM: turns a valid/ready byte stream of
// printable codes and control bytes into RAM writes while tracking a text cursor.
module jtframe_msg_writer #(
  parameter int unsigned SW      = 10,
  parameter int unsigned COLW    = 5,
  parameter logic [7:0]  CLRCHAR = 8'h20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic          busy,
  output logic [SW-1:0] cursor,
  output logic [SW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          wr_en
);

  localparam int unsigned ROWW = SW - COLW;

  typedef enum logic [1:0] {StIdle, StPosCol, StPosRow, StClear} state_e;

  state_e        r_state;
  logic [SW-1:0] r_cursor;
  logic [SW-1:0] r_wr_addr;
  logic [7:0]    r_wr_data;
  logic          r_wr_en;

  logic w_accept;
  logic w_printable;

  assign s_ready     = rst_n & (r_state != StClear);
  assign busy        = (r_state == StClear);
  assign w_accept    = s_valid & s_ready;
  assign w_printable = (s_data >= 8'h20);

  assign cursor  = r_cursor;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign wr_en   = r_wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_cursor  <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            if (w_printable) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_cursor;
              r_wr_data <= s_data;
              // {row,col} increment: col carry rolls into row, row carry drops off
              r_cursor  <= r_cursor + SW'(1);
            end else begin
              case (s_data)
                8'h01: begin
                  // First clear write is issued here so writes line up with busy
                  r_state   <= StClear;
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= '0;
                  r_wr_data <= CLRCHAR;
                end
                8'h02:   r_cursor <= '0;
                8'h0D:   r_cursor[COLW-1:0] <= '0;
                8'h0A:   r_cursor <= {r_cursor[SW-1:COLW] + ROWW'(1), COLW'(0)};
                8'h10:   r_state <= StPosCol;
                default: ;
              endcase
            end
          end
        end
        StPosCol: begin
          if (w_accept) begin
            r_cursor[COLW-1:0] <= s_data[COLW-1:0];
            r_state            <= StPosRow;
          end
        end
        StPosRow: begin
          if (w_accept) begin
            r_cursor[SW-1:COLW] <= s_data[ROWW-1:0];
            r_state             <= StIdle;
          end
        end
        StClear: begin
          if (&r_wr_addr) begin
            r_cursor <= '0;
            r_state  <= StIdle;
          end else begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_wr_addr + SW'(1);
          end
        end
      endcase
    end
  end

endmodule
